// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer widths and the Gray-to-binary helper.
package fifo_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int PTR_W_DEF  = ADDR_W_DEF + 1;
    // Operates on a 32-bit container; zero-extended narrower Gray codes convert correctly.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/Grey_coding.sv
// Grey_coding: binary to reflected Gray code conversion.
module Grey_coding #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);
    assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: async-FIFO write pointer with full, almost-full and sticky overflow flags.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   RQ2_PTR,
    input  logic                  OVF_CLR,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [ADDR_WIDTH:0]   W_PTR,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  OVERFLOW
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [PW-1:0] wbin_q, wbin_d, wptr_q, wptr_d, rbin, level;
    logic          full_q, full_d, af_q, af_d, ovf_q, ovf_d;

    Grey_coding #(.WIDTH(PW)) u_gray (.bin_i(wbin_d), .gray_o(wptr_d));

    always_comb begin
        W_EN   = W_INC & ~full_q;
        wbin_d = wbin_q + PW'(W_EN);
        rbin   = PW'(gray2bin(32'(RQ2_PTR)));
        level  = wbin_d - rbin;
        // Full when write pointer is exactly one lap ahead: top two Gray bits inverted.
        full_d = wptr_d == {~RQ2_PTR[ADDR_WIDTH:ADDR_WIDTH-1], RQ2_PTR[ADDR_WIDTH-2:0]};
        af_d   = {1'b0, level} >= (PW+1)'(AF_LEVEL);
        ovf_d  = (W_INC & full_q) | (ovf_q & ~OVF_CLR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wbin_q <= '0;
            wptr_q <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wbin_q <= wbin_d;
            wptr_q <= wptr_d;
            full_q <= full_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
        end
    end

    assign W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
    assign W_PTR       = wptr_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = af_q;
    assign OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed and random checks of wptr_full_ctrl against a write/read count model.
module tb_wptr_full_ctrl;
    logic       CLK = 1'b0, RST = 1'b0, W_INC = 1'b0, OVF_CLR = 1'b0;
    logic [4:0] RQ2_PTR = '0;
    logic       W_EN, FULL, ALMOST_FULL, OVERFLOW;
    logic [3:0] W_ADDR;
    logic [4:0] W_PTR;

    int total = 0, bad = 0;
    int w_m = 0, r_m = 0;
    bit full_m = 0, af_m = 0, ovf_m = 0;

    wptr_full_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
        .CLK(CLK), .RST(RST), .W_INC(W_INC), .RQ2_PTR(RQ2_PTR), .OVF_CLR(OVF_CLR),
        .W_EN(W_EN), .W_ADDR(W_ADDR), .W_PTR(W_PTR),
        .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check W_EN, clock, advance model, check registered outputs.
    task automatic cycle(input bit winc, input bit clr, input bit rst);
        bit en;
        int wn, occ;
        logic [4:0] prev;
        W_INC = winc; OVF_CLR = clr; RST = rst; RQ2_PTR = gray(r_m);
        en = winc && !full_m;
        #1 chk("w_en", W_EN, en);
        prev = W_PTR;
        @(posedge CLK);
        if (rst) begin
            w_m = 0; full_m = 0; af_m = 0; ovf_m = 0;
        end else begin
            wn = (w_m + (en ? 1 : 0)) % 32;
            occ = (wn - r_m + 64) % 32;
            ovf_m = (winc && full_m) || (ovf_m && !clr);
            full_m = occ == 16;
            af_m = occ >= 12;
            w_m = wn;
        end
        #1;
        chk("w_ptr", W_PTR, gray(w_m));
        chk("w_addr", W_ADDR, w_m % 16);
        chk("full", FULL, full_m);
        chk("almost_full", ALMOST_FULL, af_m);
        chk("overflow", OVERFLOW, ovf_m);
        if (!rst) chk("one_bit_step", $countones(W_PTR ^ prev), en ? 1 : 0);
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("reset_ptr", W_PTR, 5'b00000);
        chk("reset_flags", {FULL, ALMOST_FULL, OVERFLOW}, 3'b000);
        r_m = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 0, 0);
            if (i == 11) chk("af_before_12", ALMOST_FULL, 0);
            if (i == 12) chk("af_at_12", ALMOST_FULL, 1);
            if (i == 15) chk("full_before_16", FULL, 0);
        end
        chk("fill_full", FULL, 1);
        chk("fill_ptr", W_PTR, 5'b11000);
        chk("fill_addr", W_ADDR, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        chk("ovf_set", OVERFLOW, 1);
        chk("ovf_ptr_held", W_PTR, 5'b11000);
        cycle(0, 1, 0);
        chk("ovf_clr", OVERFLOW, 0);
        cycle(1, 1, 0);
        chk("ovf_set_beats_clr", OVERFLOW, 1);
        cycle(0, 1, 0);
        r_m = 4;
        cycle(0, 0, 0);
        chk("drain_release", FULL, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        chk("drain_refull", FULL, 1);
        chk("drain_ptr", W_PTR, 5'b11110);
        for (int i = 0; i < 40; i++) begin
            r_m = (w_m + 30) % 32;
            cycle(1, 0, 0);
            chk("wrap_no_full", FULL, 0);
            if (w_m == 0) chk("wrap_ptr_zero", W_PTR, 5'b00000);
        end
        r_m = 0;
        cycle(0, 0, 1);
        for (int i = 0; i < 7; i++) cycle(1, 0, 0);
        chk("midfill_ptr", W_PTR, gray(7));
        cycle(0, 0, 1);
        chk("midfill_reset", {W_PTR, W_ADDR, FULL, ALMOST_FULL, OVERFLOW}, 0);
        cycle(1, 0, 0);
        chk("post_reset_first", W_PTR, 5'b00001);
        for (int i = 0; i < 400; i++) begin
            int occ, adv;
            bit rs;
            occ = (w_m - r_m + 64) % 32;
            adv = $urandom_range(0, 3);
            if (adv > occ) adv = occ;
            r_m = (r_m + adv) % 32;
            rs = $urandom_range(0, 99) == 0;
            if (rs) r_m = 0;
            cycle(rs ? 0 : ($urandom_range(0, 3) != 0), $urandom_range(0, 9) == 0, rs);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
